// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler with a one-entry valid/ready output buffer and a sticky overrun flag.
// Latency: word_valid rises on the edge that samples the final bit of a frame (visible the next cycle).
// Backpressure: a word completing while the buffer is full and not draining is dropped and overrun is set.
//
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_start                 : frame start pulse (aborts a partial frame)
//   i_bit_in, i_bit_en      : serial data bit and its qualifier
//   i_word_ready            : consumer accepts o_word_out this cycle
//   o_word_out, o_word_valid: buffered word and its valid flag
//   o_busy                  : frame in progress
//   o_overrun               : sticky, a completed word was dropped
module serial_word_assembler #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_bit_in,
    input  logic             i_bit_en,
    input  logic             i_word_ready,
    output logic [WIDTH-1:0] o_word_out,
    output logic             o_word_valid,
    output logic             o_busy,
    output logic             o_overrun
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sr, w_sr_nxt, w_shifted;
    logic [WIDTH-1:0] r_word, w_word_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_ovr, w_ovr_nxt;
    logic             w_complete;
    logic             w_drain;

    // Shift register contents after accepting i_bit_in this cycle.
    generate
        if (MSB_FIRST) begin : g_msb
            assign w_shifted = {r_sr[WIDTH-2:0], i_bit_in};
        end else begin : g_lsb
            assign w_shifted = {i_bit_in, r_sr[WIDTH-1:1]};
        end
    endgenerate

    assign w_drain = r_valid & i_word_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;
        w_valid_nxt = r_valid;
        w_ovr_nxt   = r_ovr;
        w_complete  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_nxt   = '0;
                    if (i_bit_en) begin
                        w_sr_nxt  = w_shifted;
                        w_cnt_nxt = CW'(1);
                    end
                end
            end
            ST_SHIFT: begin
                if (i_bit_en && (r_cnt == LAST)) begin
                    // Completion wins over a same-cycle start: the bit closes
                    // this frame and a start only re-arms an empty new frame.
                    w_complete  = 1'b1;
                    w_sr_nxt    = w_shifted;
                    w_cnt_nxt   = '0;
                    w_state_nxt = i_start ? ST_SHIFT : ST_IDLE;
                end else if (i_start) begin
                    w_cnt_nxt = '0;
                    if (i_bit_en) begin
                        w_sr_nxt  = w_shifted;
                        w_cnt_nxt = CW'(1);
                    end
                end else if (i_bit_en) begin
                    w_sr_nxt  = w_shifted;
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Output buffer: a draining buffer can take the new word on the same edge.
        if (w_complete) begin
            if (!r_valid || i_word_ready) begin
                w_word_nxt  = w_shifted;
                w_valid_nxt = 1'b1;
            end else begin
                w_ovr_nxt = 1'b1;
            end
        end else if (w_drain) begin
            w_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_word  <= w_word_nxt;
            r_valid <= w_valid_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    assign o_word_out   = r_word;
    assign o_word_valid = r_valid;
    assign o_busy       = (r_state == ST_SHIFT);
    assign o_overrun    = r_ovr;

endmodule

// File: tb/tb_serial_word_assembler.sv
module tb_serial_word_assembler;

    localparam int W = 8;

    logic         clk;
    logic         s_rst, s_start, s_bit, s_en, s_rdy;
    logic [W-1:0] m_out, l_out;
    logic         m_vld, l_vld, m_busy, l_busy, m_ovr, l_ovr;

    int total = 0;
    int bad   = 0;

    // Two instances share stimulus: one per bit order.
    serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .i_clk(clk), .i_rst(s_rst), .i_start(s_start), .i_bit_in(s_bit),
        .i_bit_en(s_en), .i_word_ready(s_rdy), .o_word_out(m_out),
        .o_word_valid(m_vld), .o_busy(m_busy), .o_overrun(m_ovr)
    );
    serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .i_clk(clk), .i_rst(s_rst), .i_start(s_start), .i_bit_in(s_bit),
        .i_bit_en(s_en), .i_word_ready(s_rdy), .o_word_out(l_out),
        .o_word_valid(l_vld), .o_busy(l_busy), .o_overrun(l_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a frame is a list of received bits; the word is
    // assembled from that list once it holds W bits.
    bit           in_frame = 1'b0;
    bit           q[$];
    bit           mv       = 1'b0;
    bit           mo       = 1'b0;
    logic [W-1:0] mw_m     = '0;
    logic [W-1:0] mw_l     = '0;
    int           m_words  = 0;

    function automatic logic [W-1:0] pack(input bit msb);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < q.size(); i++) begin
            if (msb) w[W-1-i] = q[i];
            else     w[i]     = q[i];
        end
        return w;
    endfunction

    task automatic model_step();
        bit loaded;
        loaded = 1'b0;
        if (s_rst) begin
            in_frame = 1'b0;
            q.delete();
            mv   = 1'b0;
            mo   = 1'b0;
            mw_m = '0;
            mw_l = '0;
        end else begin
            if (in_frame && s_en && q.size() == W - 1) begin
                q.push_back(s_bit);
                m_words++;
                if (!mv || s_rdy) begin
                    mw_m   = pack(1'b1);
                    mw_l   = pack(1'b0);
                    loaded = 1'b1;
                end else begin
                    mo = 1'b1;
                end
                q.delete();
                in_frame = s_start;
            end else if (s_start) begin
                q.delete();
                in_frame = 1'b1;
                if (s_en) q.push_back(s_bit);
            end else if (in_frame && s_en) begin
                q.push_back(s_bit);
            end
            if (loaded)          mv = 1'b1;
            else if (mv && s_rdy) mv = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("busy_m",  {31'd0, m_busy}, {31'd0, in_frame});
        chk("busy_l",  {31'd0, l_busy}, {31'd0, in_frame});
        chk("valid_m", {31'd0, m_vld},  {31'd0, mv});
        chk("valid_l", {31'd0, l_vld},  {31'd0, mv});
        chk("ovr_m",   {31'd0, m_ovr},  {31'd0, mo});
        chk("ovr_l",   {31'd0, l_ovr},  {31'd0, mo});
        chk("word_m",  32'(m_out), 32'(mw_m));
        chk("word_l",  32'(l_out), 32'(mw_l));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic put(input logic st, input logic en, input logic b, input logic rdy);
        s_start = st;
        s_en    = en;
        s_bit   = b;
        s_rdy   = rdy;
        cyc();
    endtask

    // Start pulse, then the bits of v (v[W-1] first) with random idle gaps.
    task automatic frame(input logic [W-1:0] v, input int maxgap, input logic rdy, input logic rdy_last);
        put(1'b1, 1'b0, 1'b0, rdy);
        for (int i = 0; i < W; i++) begin
            int g;
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            repeat (g) put(1'b0, 1'b0, 1'($urandom), rdy);
            put(1'b0, 1'b1, v[W-1-i], (i == W - 1) ? rdy_last : rdy);
        end
    endtask

    initial begin
        int w0;
        s_rst = 1'b1; s_start = 1'b0; s_bit = 1'b0; s_en = 1'b0; s_rdy = 1'b0;
        cyc();
        cyc();
        chk("rst_valid", {31'd0, m_vld}, 32'd0);
        chk("rst_word",  32'(m_out), 32'd0);
        s_rst = 1'b0;

        // MSB first 0xB2, LSB first reads 0x4D; one-cycle valid pulse.
        frame(8'hB2, 0, 1'b1, 1'b1);
        chk("b2_word_m", 32'(m_out), 32'hB2);
        chk("b2_word_l", 32'(l_out), 32'h4D);
        chk("b2_valid",  {31'd0, m_vld}, 32'd1);
        put(1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2_valid_drop", {31'd0, m_vld}, 32'd0);

        // Same bits with random gaps.
        frame(8'hB2, 3, 1'b1, 1'b1);
        chk("gap_word_l", 32'(l_out), 32'h4D);
        put(1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure and sticky overrun.
        frame(8'hB2, 1, 1'b0, 1'b0);
        frame(8'h5A, 1, 1'b0, 1'b0);
        chk("bp_word_m", 32'(m_out), 32'hB2);
        chk("bp_ovr",    {31'd0, m_ovr}, 32'd1);
        put(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_drain_valid", {31'd0, m_vld}, 32'd0);
        chk("bp_ovr_sticky",  {31'd0, m_ovr}, 32'd1);

        // Reset mid-frame with a full buffer.
        frame(8'h3C, 0, 1'b0, 1'b0);
        put(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) put(1'b0, 1'b1, 1'b1, 1'b0);
        s_rst = 1'b1;
        put(1'b0, 1'b1, 1'b1, 1'b0);
        put(1'b1, 1'b1, 1'b0, 1'b1);
        chk("mrst_valid", {31'd0, m_vld},  32'd0);
        chk("mrst_busy",  {31'd0, m_busy}, 32'd0);
        chk("mrst_ovr",   {31'd0, m_ovr},  32'd0);
        chk("mrst_word",  32'(m_out),      32'd0);
        s_rst = 1'b0;
        frame(8'hA5, 2, 1'b1, 1'b1);
        chk("post_rst_word", 32'(m_out), 32'hA5);
        put(1'b0, 1'b0, 1'b0, 1'b1);

        // Same-edge drain is lossless.
        frame(8'hB2, 0, 1'b0, 1'b0);
        frame(8'h5A, 2, 1'b0, 1'b1);
        chk("sed_word_m", 32'(m_out), 32'h5A);
        chk("sed_valid",  {31'd0, m_vld}, 32'd1);
        chk("sed_ovr",    {31'd0, m_ovr}, 32'd0);
        put(1'b0, 1'b0, 1'b0, 1'b1);

        // Abort a partial frame.
        w0 = m_words;
        put(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) put(1'b0, 1'b1, 1'b1, 1'b1);
        frame(8'h0F, 0, 1'b1, 1'b1);
        chk("abort_word_m", 32'(m_out), 32'h0F);
        chk("abort_count",  32'(m_words - w0), 32'd1);
        chk("abort_ovr",    {31'd0, m_ovr}, 32'd0);

        // Start coincident with the completion bit.
        put(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (W - 1) put(1'b0, 1'b1, 1'b1, 1'b1);
        put(1'b1, 1'b1, 1'b0, 1'b1);
        chk("sc_word_m", 32'(m_out), 32'hFE);
        chk("sc_busy",   {31'd0, m_busy}, 32'd1);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            s_rst = ($urandom_range(0, 499) == 0);
            put(($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0),
                1'($urandom), 1'($urandom));
        end
        s_rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_word_assembler.md
# serial_word_assembler

Serial-to-parallel capture stage that sits directly downstream of the lab's registered single-bit D flip-flop stage. It consumes that stage's registered Q output one bit at a time, assembles framed WIDTH-bit words, and presents each completed word in a one-entry output buffer with a valid/ready handshake. It also flags, with a sticky flag, any completed word that had to be dropped because the buffer was still full.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, bit order. 1 = first received bit becomes word_out[WIDTH-1]. 0 = first received bit becomes word_out[0].

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- start  in  1  frame start; a one-cycle pulse.
- bit_in  in  1  serial data bit, taken from the upstream flip-flop's Q.
- bit_en  in  1  qualifies bit_in for this cycle.
- word_ready  in  1  the consumer accepts word_out this cycle.
- word_out  out  WIDTH  assembled word; stable while word_valid=1.
- word_valid  out  1  word_out holds an unconsumed word.
- busy  out  1  a frame is in progress (state SHIFT).
- overrun  out  1  sticky flag: a completed word was dropped.

## Operation
- Internal state: a 2-state FSM (IDLE, SHIFT), a shift register sr[WIDTH-1:0], and a bit counter cnt of width clog2(WIDTH).
- IDLE:
  - bit_en is ignored.
  - start=1 moves the FSM to SHIFT with cnt=0.
  - If bit_en=1 in the same cycle as start, that bit is captured as bit 0 of the frame and cnt=1.
- SHIFT, each cycle with bit_en=1:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], bit_in}.
  - MSB_FIRST=0: sr <= {bit_in, sr[WIDTH-1:1]}.
  - cnt increments.
  - Cycles with bit_en=0 hold sr and cnt. Gaps of any length are legal.
- Frame completion: a bit_en=1 cycle with cnt==WIDTH-1.
  - The completed word is the shifted value including this bit.
  - The FSM returns to IDLE and cnt returns to 0.
  - If the buffer is empty, or is drained this same cycle (word_valid=1 and word_ready=1), the word is loaded into word_out and word_valid=1.
  - Otherwise the word is discarded, overrun is set to 1, and word_out is unchanged.
- start=1 while in SHIFT aborts the partial frame. cnt resets to 0 and the FSM stays in SHIFT. A same-cycle bit_en bit becomes bit 0 of the new frame. No word is produced and overrun is not set.
- Handshake: the buffer is consumed on any cycle with word_valid=1 and word_ready=1. word_valid then falls next cycle unless a new word loads in that same cycle. word_ready while word_valid=0 has no effect.
- overrun clears only on rst.
- busy = (state == SHIFT).

## Timing
- Reset values: state=IDLE, cnt=0, sr=0, word_out=0, word_valid=0, busy=0, overrun=0.
- rst has priority over every other input in the same cycle. It clears the buffer even if word_valid=1, and aborts a frame in progress.
- Latency: word_valid rises on the clock edge that samples the final bit_en. It is visible in the cycle after the last bit is presented.
- busy rises on the edge that samples start. It falls on the completion edge.
- Maximum throughput: one word per WIDTH cycles, with bit_en held high, start pulsed each frame, and word_ready held high. This rate produces no overrun.
- Simultaneous completion and drain is lossless: the old word is consumed and the new word is loaded on the same edge.
- Simultaneous start and completion bit: completion takes effect (word produced), then the FSM enters SHIFT with cnt=0. The start-cycle bit is not double-counted; it is the completion bit.

## Test plan
- Reset: assert rst for 2 cycles mid-frame with word_valid=1 -> all outputs 0 on the next cycle, and a fresh frame after reset assembles correctly.
- MSB_FIRST=1, WIDTH=8: start, then bits 1,0,1,1,0,0,1,0 on consecutive bit_en cycles, word_ready=1 -> word_out=0xB2 and word_valid=1 for exactly 1 cycle, one cycle after the last bit.
- MSB_FIRST=0, same bits, with bit_en gaps of 0-3 random idle cycles -> word_out=0x4D and busy=1 throughout the frame.
- Backpressure: word_ready=0. Frame 0xB2 completes, then frame 0x5A completes -> word_out stays 0xB2, overrun=1 and remains 1. Then word_ready=1 -> word_valid falls the next cycle.
- Same-edge drain: word_valid=1 (0xB2), and word_ready=1 on the completion edge of frame 0x5A -> word_out=0x5A, word_valid stays 1, overrun=0.
- Abort: start, bits 1,1,1, start again, then bits 0,0,0,0,1,1,1,1 -> exactly one word, 0x0F (MSB_FIRST=1), and no overrun.
